sign_extension: RTL and testbench

SIGN_EXTENSION -- requirements
Module: Sign_Extension

---
 rtl/sign_extension.sv | 73 +++++++
 tb/tb_sign_extension.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sign_extension.sv
// sign_extension: widens an IN_W-bit field to OUT_W bits, by sign or zero fill, and
// registers the result after a small logical left shift.
//
// Ports:
//   clk        - rising-edge clock for all registers
//   rst_n      - asynchronous active-low reset
//   in_sign    - IN_W-bit value to extend
//   in_valid   - qualifies in_sign, ext_mode and shamt for capture
//   ext_mode   - 0: sign extension, 1: zero extension
//   shamt      - left-shift amount (0..3) applied after extension
//   out_sign   - registered, shifted, extended value (holds when in_valid is low)
//   out_valid  - registered valid flag for out_sign
//   out_comb   - combinational extended value of in_sign (no shift, ignores in_valid)
module sign_extension #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_sign,
  input  logic             in_valid,
  input  logic             ext_mode,
  input  logic [1:0]       shamt,
  output logic [OUT_W-1:0] out_sign,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_comb
);

  logic [OUT_W-1:0] ext_val;
  logic [OUT_W-1:0] shifted;
  logic [OUT_W-1:0] out_sign_d, out_sign_q;
  logic             out_valid_d, out_valid_q;
  logic             fill_bit;

  if (OUT_W < IN_W) begin : gen_bad_width
    $error("sign_extension: OUT_W must be >= IN_W");
  end

  assign fill_bit = ext_mode ? 1'b0 : in_sign[IN_W-1];

  // Equal widths leave nothing to fill, so the extension collapses to a wire.
  if (OUT_W > IN_W) begin : gen_extend
    assign ext_val = {{(OUT_W - IN_W){fill_bit}}, in_sign};
  end else begin : gen_identity
    assign ext_val = in_sign;
  end

  // Logical shift: bits leave at the top, zeros enter at the bottom.
  assign shifted  = ext_val << shamt;
  assign out_comb = ext_val;

  always_comb begin
    out_sign_d  = out_sign_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_sign_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sign_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_sign_q  <= out_sign_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_sign  = out_sign_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extension.sv
module tb_sign_extension;

  logic       clk;
  logic       rst_n;
  logic [2:0] in_sign;
  logic       in_valid;
  logic       ext_mode;
  logic [1:0] shamt;
  logic [7:0] out_sign;
  logic       out_valid;
  logic [7:0] out_comb;

  // Equal-width instance: extension must be the identity.
  logic [3:0] eq_in;
  logic       eq_valid;
  logic       eq_mode;
  logic [1:0] eq_shamt;
  logic [3:0] eq_sign;
  logic       eq_out_valid;
  logic [3:0] eq_comb;

  int checks;
  int failures;

  sign_extension #(.IN_W(3), .OUT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_sign  (in_sign),
    .in_valid (in_valid),
    .ext_mode (ext_mode),
    .shamt    (shamt),
    .out_sign (out_sign),
    .out_valid(out_valid),
    .out_comb (out_comb)
  );

  sign_extension #(.IN_W(4), .OUT_W(4)) dut_eq (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_sign  (eq_in),
    .in_valid (eq_valid),
    .ext_mode (eq_mode),
    .shamt    (eq_shamt),
    .out_sign (eq_sign),
    .out_valid(eq_out_valid),
    .out_comb (eq_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: treat the field as a signed or unsigned integer, multiply by 2**shamt,
  // and keep the low byte (two's complement wraps naturally).
  function automatic logic [7:0] model8(input logic [2:0] v, input logic zm, input int sh);
    int val;
    val = int'(v);
    if (!zm && val >= 4) val = val - 8;
    val = val * (1 << sh);
    return val[7:0];
  endfunction

  function automatic logic [3:0] model4(input logic [3:0] v, input int sh);
    int val;
    val = int'(v) * (1 << sh);
    return val[3:0];
  endfunction

  typedef struct {
    logic [2:0] in_sign;
    logic       ext_mode;
    logic [1:0] shamt;
    logic [7:0] exp_comb;
    logic [7:0] exp_sign;
  } vec_t;

  vec_t vecs[9];

  logic [7:0] exp_sign_q;
  logic [3:0] exp_eq_q;
  logic       exp_valid;

  initial begin
    vecs[0] = '{3'b011, 1'b0, 2'd0, 8'h03, 8'h03};
    vecs[1] = '{3'b100, 1'b0, 2'd0, 8'hFC, 8'hFC};
    vecs[2] = '{3'b111, 1'b0, 2'd0, 8'hFF, 8'hFF};
    vecs[3] = '{3'b000, 1'b0, 2'd0, 8'h00, 8'h00};
    vecs[4] = '{3'b100, 1'b1, 2'd2, 8'h04, 8'h10};
    vecs[5] = '{3'b101, 1'b0, 2'd3, 8'hFD, 8'hE8};
    vecs[6] = '{3'b111, 1'b0, 2'd3, 8'hFF, 8'hF8};
    vecs[7] = '{3'b011, 1'b1, 2'd1, 8'h03, 8'h06};
    vecs[8] = '{3'b110, 1'b1, 2'd3, 8'h06, 8'h30};

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_sign  = 3'b000;
    in_valid = 1'b0;
    ext_mode = 1'b0;
    shamt    = 2'd0;
    eq_in    = 4'd0;
    eq_valid = 1'b0;
    eq_mode  = 1'b0;
    eq_shamt = 2'd0;

    // Reset state, and the combinational path still working under reset.
    #1;
    chk("reset_out_sign", out_sign, 8'h00);
    chk("reset_out_valid", {7'd0, out_valid}, 8'h00);
    in_sign  = 3'b110;
    in_valid = 1'b1;
    #1;
    chk("comb_during_reset", out_comb, 8'hFE);
    @(posedge clk);
    #1;
    chk("reset_holds_over_edge", out_sign, 8'h00);
    chk("reset_holds_valid", {7'd0, out_valid}, 8'h00);

    // Release with in_valid low: nothing captured until the first valid edge.
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_release_sign", out_sign, 8'h00);
    chk("idle_after_release_valid", {7'd0, out_valid}, 8'h00);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_sign  = vecs[i].in_sign;
      ext_mode = vecs[i].ext_mode;
      shamt    = vecs[i].shamt;
      in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_comb", i), out_comb, vecs[i].exp_comb);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_sign", i), out_sign, vecs[i].exp_sign);
      chk($sformatf("vec%0d_valid", i), {7'd0, out_valid}, 8'h01);
    end

    // Capture 8'h03 then idle for three cycles with junk on the inputs.
    @(negedge clk);
    in_sign  = 3'b011;
    ext_mode = 1'b0;
    shamt    = 2'd0;
    in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sign  = 3'bxx1;
      shamt    = 2'd3;
      ext_mode = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_sign", i), out_sign, 8'h03);
      chk($sformatf("hold%0d_valid", i), {7'd0, out_valid}, 8'h00);
    end
    // out_comb ignores in_valid and shamt.
    @(negedge clk);
    in_sign = 3'b101;
    #1;
    chk("comb_ignores_valid_shamt", out_comb, 8'hFD);

    // Mid-stream asynchronous reset between edges.
    in_valid = 1'b1;
    shamt    = 2'd0;
    @(posedge clk);
    #1;
    chk("pre_reset_sign", out_sign, 8'hFD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_sign", out_sign, 8'h00);
    chk("async_reset_valid", {7'd0, out_valid}, 8'h00);
    @(negedge clk);
    rst_n    = 1'b1;
    in_sign  = 3'b011;
    ext_mode = 1'b0;
    shamt    = 2'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_capture_sign", out_sign, 8'h06);
    chk("post_reset_capture_valid", {7'd0, out_valid}, 8'h01);

    // Randomised run against the arithmetic model, both instances.
    exp_sign_q = out_sign;
    exp_eq_q   = 4'd0;
    eq_valid   = 1'b0;
    @(posedge clk);
    #1;
    exp_sign_q = 8'h06;
    chk("eq_idle_sign", {4'd0, eq_sign}, 8'h00);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      in_sign  = 3'($urandom);
      ext_mode = 1'($urandom);
      shamt    = 2'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      eq_in    = 4'($urandom);
      eq_mode  = 1'($urandom);
      eq_shamt = 2'($urandom);
      eq_valid = ($urandom_range(0, 3) != 0);
      #1;
      chk("rand_comb", out_comb, model8(in_sign, ext_mode, 0));
      chk("rand_eq_comb", {4'd0, eq_comb}, {4'd0, eq_in});
      if (in_valid) exp_sign_q = model8(in_sign, ext_mode, int'(shamt));
      if (eq_valid) exp_eq_q = model4(eq_in, int'(eq_shamt));
      exp_valid = in_valid;
      @(posedge clk);
      #1;
      chk("rand_sign", out_sign, exp_sign_q);
      chk("rand_valid", {7'd0, out_valid}, {7'd0, exp_valid});
      chk("rand_eq_sign", {4'd0, eq_sign}, {4'd0, exp_eq_q});
      chk("rand_eq_valid", {7'd0, eq_out_valid}, {7'd0, eq_valid});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
